ahblite_timer_sched: RTL and testbench

AHB-Lite slave that shares one prescaled tick generator among NCH independent timer channels. Each channel is a reloadable down-counter with one-shot or periodic mode. Expiries are latched into a pending register and merged into one maskable interrupt. A priority-resolved ACTIVE register tells the Cortex-M0 ISR which channel to service. Sits on the AHB-Lite matrix beside the simple timer slave.

---
 rtl/ahblite_timer_sched.sv | 169 ++++++++++++++++
 tb/tb_ahblite_timer_sched.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ahblite_timer_sched.sv
// AHB-Lite timer scheduler: one shared prescaled tick drives NCH reloadable
// down-counters whose expiries latch into PEND and merge into timer_irq.
module ahblite_timer_sched #(
    parameter int NCH = 4,
    parameter int CW  = 32
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic [3:0]  HPROT,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        HRESP,
    output logic        timer_irq
);

    logic [5:0]     addr_reg;
    logic           wr_reg;
    logic           valid_reg;
    logic           wr_en;

    logic           en_reg;
    logic [15:0]    presc_reg;
    logic [15:0]    presc_cnt_reg;
    logic [CW-1:0]  now_reg;
    logic [NCH-1:0] pend_reg;
    logic [NCH-1:0] irqen_reg;
    logic           tick;

    logic [NCH-1:0] expire;
    logic [NCH-1:0] cen_vec;
    logic [NCH-1:0] periodic_vec;
    logic [CW-1:0]  period_arr [NCH];
    logic [NCH-1:0] masked;
    logic           act_valid;
    logic [2:0]     act_idx;

    logic           unused_bits;
    assign unused_bits = ^{HSIZE, HPROT, HADDR[31:8], HADDR[1:0], HWDATA};

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_reg  <= '0;
            wr_reg    <= 1'b0;
            valid_reg <= 1'b0;
        end else if (HREADY) begin
            valid_reg <= HSEL & HTRANS[1];
            addr_reg  <= HADDR[7:2];
            wr_reg    <= HWRITE;
        end
    end

    assign wr_en = valid_reg & wr_reg & HREADY;

    // A PRESC write below the running count still ticks instead of waiting for a 16-bit wrap.
    assign tick = en_reg && (presc_cnt_reg >= presc_reg);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            en_reg        <= 1'b0;
            presc_reg     <= '0;
            presc_cnt_reg <= '0;
            now_reg       <= '0;
            pend_reg      <= '0;
            irqen_reg     <= '0;
        end else begin
            if (wr_en && addr_reg == 6'd0) en_reg    <= HWDATA[0];
            if (wr_en && addr_reg == 6'd1) presc_reg <= HWDATA[15:0];
            if (wr_en && addr_reg == 6'd4) irqen_reg <= HWDATA[NCH-1:0];

            if (!en_reg || tick) presc_cnt_reg <= '0;
            else                 presc_cnt_reg <= presc_cnt_reg + 16'd1;

            if (tick) now_reg <= now_reg + 1'b1;

            // Hardware set is OR'd after the clear so a same-cycle expiry wins.
            pend_reg <= (pend_reg & ~((wr_en && addr_reg == 6'd3) ? HWDATA[NCH-1:0] : '0))
                        | expire;
        end
    end

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic [CW-1:0] period_reg;
            logic [CW-1:0] cnt_reg;
            logic          cen_reg;
            logic          periodic_reg;
            logic          wr_per;
            logic          wr_cc;

            assign wr_per = wr_en && (addr_reg == 6'(8 + 2 * gi));
            assign wr_cc  = wr_en && (addr_reg == 6'(9 + 2 * gi));

            assign expire[gi]       = tick && cen_reg && !wr_cc && (cnt_reg == '0);
            assign cen_vec[gi]      = cen_reg;
            assign periodic_vec[gi] = periodic_reg;
            assign period_arr[gi]   = period_reg;

            always_ff @(posedge HCLK or negedge HRESETn) begin
                if (!HRESETn) begin
                    period_reg   <= '0;
                    cnt_reg      <= '0;
                    cen_reg      <= 1'b0;
                    periodic_reg <= 1'b0;
                end else begin
                    if (wr_per) period_reg <= HWDATA[CW-1:0];
                    // A control write overrides whatever the tick would have done this cycle.
                    if (wr_cc) begin
                        cen_reg      <= HWDATA[0];
                        periodic_reg <= HWDATA[1];
                        if (HWDATA[0]) cnt_reg <= period_reg;
                    end else if (tick && cen_reg) begin
                        if (cnt_reg == '0) begin
                            if (periodic_reg) cnt_reg <= period_reg;
                            else              cen_reg <= 1'b0;
                        end else begin
                            cnt_reg <= cnt_reg - 1'b1;
                        end
                    end
                end
            end
        end
    endgenerate

    assign masked    = pend_reg & irqen_reg;
    assign timer_irq = |masked;

    always_comb begin
        act_valid = 1'b0;
        act_idx   = 3'd0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (masked[i]) begin
                act_valid = 1'b1;
                act_idx   = 3'(i);
            end
        end
    end

    always_comb begin
        HRDATA = '0;
        case (addr_reg)
            6'd0: HRDATA[0]       = en_reg;
            6'd1: HRDATA[15:0]    = presc_reg;
            6'd2: HRDATA[CW-1:0]  = now_reg;
            6'd3: HRDATA[NCH-1:0] = pend_reg;
            6'd4: HRDATA[NCH-1:0] = irqen_reg;
            6'd5: begin
                HRDATA[31]  = act_valid;
                HRDATA[2:0] = act_idx;
            end
            default: begin
                for (int i = 0; i < NCH; i++) begin
                    if (addr_reg == 6'(8 + 2 * i)) HRDATA[CW-1:0] = period_arr[i];
                    if (addr_reg == 6'(9 + 2 * i)) HRDATA[1:0]    = {periodic_vec[i], cen_vec[i]};
                end
            end
        endcase
    end

endmodule

// File: tb/tb_ahblite_timer_sched.sv
// Directed bench for ahblite_timer_sched: bus-level register accesses with
// hand-computed expectations for tick timing, expiry, PEND/ACTIVE and reset.
module tb_ahblite_timer_sched;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;
    logic        timer_irq;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    ahblite_timer_sched #(.NCH(4), .CW(32)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE),
        .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
        .HRDATA(HRDATA), .HRESP(HRESP), .timer_irq(timer_irq)
    );

    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    // Address phase at the first edge, data committed at the second edge after it.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = 1'b1;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
        @(posedge HCLK); #1;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = 1'b0;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        d = HRDATA;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(tag, d, exp);
    endtask

    task automatic wait_irq(output int c);
        int k = 0;
        while (!timer_irq && k < 200) begin
            @(posedge HCLK); #1;
            k++;
        end
        c = cyc;
        check("irq_rise_within_bound", {31'd0, timer_irq}, 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        int c0, c1, c2;

        HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HSIZE = 3'b010;
        HPROT = 4'h3; HWRITE = 1'b0; HWDATA = '0; HREADY = 1'b1;
        idle(3);
        HRESETn = 1'b1;

        // Reset state
        check("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        check("rst_hresp", {31'd0, HRESP}, 32'd0);
        check("rst_irq", {31'd0, timer_irq}, 32'd0);
        read_check("rst_ctrl",   32'h00, 32'h0);
        read_check("rst_presc",  32'h04, 32'h0);
        read_check("rst_now",    32'h08, 32'h0);
        read_check("rst_pend",   32'h0C, 32'h0);
        read_check("rst_irqen",  32'h10, 32'h0);
        read_check("rst_active", 32'h14, 32'h0);
        read_check("rst_per0",   32'h20, 32'h0);
        read_check("rst_cc0",    32'h24, 32'h0);
        read_check("unmapped_rd", 32'h18, 32'h0);

        // Periodic ch0: PRESC=3, PERIOD=4 -> 20 cycles between expiries
        bus_write(32'h04, 32'd3);
        bus_write(32'h20, 32'd4);
        bus_write(32'h10, 32'h1);
        bus_write(32'h24, 32'h3);
        bus_write(32'h00, 32'h1);
        read_check("presc_rb", 32'h04, 32'd3);
        wait_irq(c1);
        bus_write(32'h0C, 32'h1);
        check("irq_after_w1c", {31'd0, timer_irq}, 32'd0);
        wait_irq(c2);
        check("periodic_interval", 32'(c2 - c1), 32'd20);
        bus_read(32'h08, a);
        idle(6);
        bus_read(32'h08, b);
        check("now_8cyc_delta", b - a, 32'd2);

        // One-shot ch1, PERIOD=0, PRESC=0
        bus_write(32'h24, 32'h0);
        bus_write(32'h00, 32'h0);
        bus_write(32'h04, 32'h0);
        bus_write(32'h0C, 32'hF);
        bus_write(32'h10, 32'h2);
        bus_write(32'h28, 32'h0);
        bus_write(32'h2C, 32'h1);
        bus_write(32'h00, 32'h1);
        wait_irq(c0);
        read_check("oneshot_pend", 32'h0C, 32'h2);
        read_check("oneshot_cc1_cleared", 32'h2C, 32'h0);
        bus_write(32'h0C, 32'h2);
        idle(10);
        read_check("oneshot_no_repeat", 32'h0C, 32'h0);

        // ch0 and ch2 expire on the same tick
        bus_write(32'h00, 32'h0);
        bus_write(32'h20, 32'd2);
        bus_write(32'h30, 32'd2);
        bus_write(32'h24, 32'h1);
        bus_write(32'h34, 32'h1);
        bus_write(32'h10, 32'h5);
        bus_write(32'h00, 32'h1);
        idle(5);
        read_check("dual_pend", 32'h0C, 32'h5);
        read_check("dual_active0", 32'h14, 32'h8000_0000);
        check("dual_irq", {31'd0, timer_irq}, 32'd1);
        bus_write(32'h0C, 32'h1);
        read_check("dual_active2", 32'h14, 32'h8000_0002);
        bus_write(32'h10, 32'h4);
        bus_write(32'h0C, 32'h4);
        bus_write(32'h24, 32'h1);
        idle(5);
        read_check("masked_pend", 32'h0C, 32'h1);
        read_check("masked_active", 32'h14, 32'h0);
        check("masked_irq", {31'd0, timer_irq}, 32'd0);

        // W1C in the exact cycle ch0 expires: load at edge E, expiry and W1C at E+3
        bus_write(32'h0C, 32'hF);
        bus_write(32'h24, 32'h3);
        bus_write(32'h0C, 32'h1);
        read_check("set_beats_w1c", 32'h0C, 32'h1);
        bus_write(32'h24, 32'h0);
        bus_write(32'h0C, 32'hF);

        // EN cleared mid-count: ch3 loads 5, three ticks leave cnt=2, then holds
        bus_write(32'h10, 32'h8);
        bus_write(32'h38, 32'd5);
        bus_write(32'h3C, 32'h1);
        bus_write(32'h00, 32'h0);
        bus_read(32'h08, a);
        idle(6);
        bus_read(32'h08, b);
        check("now_hold", b, a);
        check("hold_no_expiry", {31'd0, timer_irq}, 32'd0);
        bus_write(32'h00, 32'h1);
        c0 = cyc;
        wait_irq(c1);
        check("resume_remaining_ticks", 32'(c1 - c0), 32'd3);

        // Asynchronous reset mid-operation
        #2;
        HRESETn = 1'b0;
        #1;
        check("async_rst_irq", {31'd0, timer_irq}, 32'd0);
        idle(2);
        HRESETn = 1'b1;
        read_check("post_rst_ctrl",  32'h00, 32'h0);
        read_check("post_rst_now",   32'h08, 32'h0);
        read_check("post_rst_pend",  32'h0C, 32'h0);
        read_check("post_rst_per3",  32'h38, 32'h0);
        read_check("post_rst_cc3",   32'h3C, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
